// File: rtl/udma_rx_packer.sv
// udma_rx_packer: packs 16-bit HyperBus PHY read beats into 32-bit
// little-endian words for the uDMA RX channel.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   trans_start_i         start pulse; samples cfg_len_i, cfg_odd_saddr_i, mem_sel_i
//   cfg_len_i             transfer length in bytes
//   cfg_odd_saddr_i       odd start address, first received byte is dropped
//   mem_sel_i             memory type, bit 1 selects byte-swapped halfwords
//   phy_valid_i/ready_o   PHY beat handshake, phy_data_i carries the beat
//   dst_valid_o/ready_i   packed word handshake, data_o carries the word
//   busy_o                transfer in progress
//   done_o                one-cycle pulse after the last word is accepted
module udma_rx_packer #(
    parameter int TRANS_SIZE = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  trans_start_i,
    input  logic [TRANS_SIZE-1:0] cfg_len_i,
    input  logic                  cfg_odd_saddr_i,
    input  logic [1:0]            mem_sel_i,
    input  logic                  phy_valid_i,
    output logic                  phy_ready_o,
    input  logic [15:0]           phy_data_i,
    output logic                  dst_valid_o,
    input  logic                  dst_ready_i,
    output logic [31:0]           data_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [TRANS_SIZE-1:0] remaining, remaining_nxt;
    logic                  odd_q, odd_nxt;
    logic                  swap_q, swap_nxt;
    logic                  first_q, first_nxt;
    logic [23:0]           acc, acc_nxt;
    logic [1:0]            acc_n, acc_n_nxt;
    logic [31:0]           out_q, out_nxt;
    logic                  out_vld, out_vld_nxt;

    // Only bit 1 of the memory type matters for the byte order.
    logic                  sel_unused;
    assign sel_unused = mem_sel_i[0];

    logic                  out_free;
    logic                  drain;
    logic                  beat;
    logic [7:0]            b0, b1;
    logic [7:0]            nb0, nb1;
    logic [1:0]            n_av;
    logic [1:0]            kept;
    logic [2:0]            total;
    logic [5:0]            pos0, pos1;
    logic [39:0]           merged;
    logic [TRANS_SIZE-1:0] rem_after;
    logic                  load;
    logic [31:0]           load_word;

    assign out_free = !out_vld || dst_ready_i;
    assign drain    = out_vld && dst_ready_i;

    assign phy_ready_o = (state == RUN) && (remaining != '0) && out_free;
    assign beat        = phy_valid_i && phy_ready_o;

    // Byte order of the beat as seen by the memory.
    always_comb begin
        if (swap_q) begin
            b0 = phy_data_i[15:8];
            b1 = phy_data_i[7:0];
        end else begin
            b0 = phy_data_i[7:0];
            b1 = phy_data_i[15:8];
        end
    end

    // On an odd start the first beat contributes only its upper byte.
    always_comb begin
        if (first_q && odd_q) begin
            n_av = 2'd1;
            nb0  = b1;
            nb1  = 8'h00;
        end else begin
            n_av = 2'd2;
            nb0  = b0;
            nb1  = b1;
        end
    end

    // Bytes past the programmed length are dropped.
    always_comb begin
        kept = 2'd0;
        if (beat) begin
            if (remaining >= TRANS_SIZE'(n_av)) begin
                kept = n_av;
            end else begin
                kept = remaining[1:0];
            end
        end
    end

    assign total     = {1'b0, acc_n} + {1'b0, kept};
    assign rem_after = remaining - TRANS_SIZE'(kept);
    assign pos0      = {1'b0, acc_n, 3'b000};
    assign pos1      = pos0 + 6'd8;

    // Accumulator with the kept bytes appended; upper lanes stay zero,
    // so a short result is already a zero-padded final word.
    always_comb begin
        merged = {16'h0000, acc};
        if (kept != 2'd0) begin
            merged[pos0 +: 8] = nb0;
        end
        if (kept == 2'd2) begin
            merged[pos1 +: 8] = nb1;
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        odd_nxt       = odd_q;
        swap_nxt      = swap_q;
        first_nxt     = first_q;
        acc_nxt       = acc;
        acc_n_nxt     = acc_n;
        load          = 1'b0;
        load_word     = 32'h0;

        unique case (state)
            IDLE: begin
                if (trans_start_i) begin
                    remaining_nxt = cfg_len_i;
                    odd_nxt       = cfg_odd_saddr_i;
                    swap_nxt      = mem_sel_i[1];
                    first_nxt     = 1'b1;
                    acc_nxt       = 24'h0;
                    acc_n_nxt     = 2'd0;
                    if (cfg_len_i != '0) begin
                        state_nxt = RUN;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            RUN: begin
                if (beat) begin
                    first_nxt     = 1'b0;
                    remaining_nxt = rem_after;
                    if (total >= 3'd4) begin
                        // Full word; a fifth byte carries over to lane 0.
                        load      = 1'b1;
                        load_word = merged[31:0];
                        acc_nxt   = {16'h0000, merged[39:32]};
                        acc_n_nxt = total[1:0];
                    end else if (rem_after == '0) begin
                        load      = 1'b1;
                        load_word = merged[31:0];
                        acc_nxt   = 24'h0;
                        acc_n_nxt = 2'd0;
                    end else begin
                        acc_nxt   = merged[23:0];
                        acc_n_nxt = total[1:0];
                    end
                end else if (remaining == '0 && acc_n != 2'd0 && out_free) begin
                    // Carried byte left over after the last beat.
                    load      = 1'b1;
                    load_word = {8'h00, acc};
                    acc_nxt   = 24'h0;
                    acc_n_nxt = 2'd0;
                end
                if (load && remaining_nxt == '0 && acc_n_nxt == 2'd0) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (drain) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        out_nxt     = out_q;
        out_vld_nxt = out_vld;
        if (load) begin
            out_nxt     = load_word;
            out_vld_nxt = 1'b1;
        end else if (drain) begin
            out_vld_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            remaining <= '0;
            odd_q     <= 1'b0;
            swap_q    <= 1'b0;
            first_q   <= 1'b0;
            acc       <= 24'h0;
            acc_n     <= 2'd0;
            out_q     <= 32'h0;
            out_vld   <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            odd_q     <= odd_nxt;
            swap_q    <= swap_nxt;
            first_q   <= first_nxt;
            acc       <= acc_nxt;
            acc_n     <= acc_n_nxt;
            out_q     <= out_nxt;
            out_vld   <= out_vld_nxt;
        end
    end

    assign dst_valid_o = out_vld;
    assign data_o      = out_q;
    assign busy_o      = (state == RUN) || (state == FLUSH);
    assign done_o      = (state == DONE);

endmodule

// File: tb/tb_udma_rx_packer.sv
// Testbench for udma_rx_packer: directed transfers checked against a
// byte-stream model of the packer, plus literal word expectations.
module tb_udma_rx_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        trans_start;
    logic [15:0] cfg_len;
    logic        cfg_odd;
    logic [1:0]  mem_sel;
    logic        phy_valid;
    logic        phy_ready;
    logic [15:0] phy_data;
    logic        dst_valid;
    logic        dst_ready;
    logic [31:0] data;
    logic        busy;
    logic        done;

    udma_rx_packer #(.TRANS_SIZE(16)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .trans_start_i   (trans_start),
        .cfg_len_i       (cfg_len),
        .cfg_odd_saddr_i (cfg_odd),
        .mem_sel_i       (mem_sel),
        .phy_valid_i     (phy_valid),
        .phy_ready_o     (phy_ready),
        .phy_data_i      (phy_data),
        .dst_valid_o     (dst_valid),
        .dst_ready_i     (dst_ready),
        .data_o          (data),
        .busy_o          (busy),
        .done_o          (done)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          beat_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [15:0] bt[8];
    bit          last_acc = 1'b0;
    bit          hold_prev = 1'b0;
    logic [31:0] data_prev = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
        end
    endtask

    task automatic load8(input logic [127:0] v);
        for (int i = 0; i < 8; i++) bt[i] = v[16*i +: 16];
    endtask

    // Byte-stream model: order bytes, drop the odd lead byte, cut to
    // length, then group by four with zero fill.
    task automatic model(input int ln, input bit odd, input bit sw, input int nb);
        logic [7:0]  q[$];
        logic [31:0] w;
        for (int i = 0; i < nb; i++) begin
            if (sw) begin
                q.push_back(bt[i][15:8]);
                q.push_back(bt[i][7:0]);
            end else begin
                q.push_back(bt[i][7:0]);
                q.push_back(bt[i][15:8]);
            end
        end
        if (odd && q.size() > 0) void'(q.pop_front());
        while (q.size() > ln) void'(q.pop_back());
        for (int b = 0; b < q.size(); b += 4) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++)
                if (b + k < q.size()) w[8*k +: 8] = q[b + k];
            exp_q.push_back(w);
        end
    endtask

    // Compare process: every cycle, checked at the falling edge.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (last_acc) begin
                chk("done_after_last_word", 32'(done), 32'd1);
                last_acc = 1'b0;
            end
            if (done) done_cnt++;
            if (hold_prev) begin
                chk("hold_valid", 32'(dst_valid), 32'd1);
                chk("hold_data", data, data_prev);
            end
            hold_prev = dst_valid && !dst_ready;
            data_prev = data;
            if (phy_valid && phy_ready) beat_cnt++;
            if (dst_valid && dst_ready) begin
                got_q.push_back(data);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL extra_word: got %08h, expected no word", data);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", data, e);
                    if (exp_q.size() == 0) last_acc = 1'b1;
                end
            end
        end
    end

    task automatic start(input int ln, input bit odd, input logic [1:0] ms, input int nb);
        model(ln, odd, ms[1], nb);
        @(posedge clk); #1;
        cfg_len = 16'(ln);
        cfg_odd = odd;
        mem_sel = ms;
        trans_start = 1'b1;
        @(posedge clk); #1;
        trans_start = 1'b0;
        // Configuration must have been captured at start.
        cfg_len = 16'hFFFF;
        cfg_odd = 1'b0;
        mem_sel = 2'b00;
    endtask

    task automatic send(input int nb);
        bit ok;
        for (int i = 0; i < nb; i++) begin
            phy_valid = 1'b1;
            phy_data = bt[i];
            ok = 1'b0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if (phy_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("beat_accepted", 32'(ok), 32'd1);
            @(posedge clk); #1;
        end
        phy_valid = 1'b0;
        phy_data = 16'h0;
    endtask

    task automatic wait_done(input int d0);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done_cnt > d0) break;
        end
        repeat (3) @(negedge clk);
        chk("done_count", 32'(done_cnt - d0), 32'd1);
        chk("model_drained", 32'(exp_q.size()), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic run(input int ln, input bit odd, input logic [1:0] ms, input int nb);
        int d0, b0;
        d0 = done_cnt;
        b0 = beat_cnt;
        got_q.delete();
        start(ln, odd, ms, nb);
        send(nb);
        wait_done(d0);
        chk("beats_taken", 32'(beat_cnt - b0), 32'(nb));
    endtask

    task automatic stall();
        bit found;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (dst_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("bp_first_word", 32'(found), 32'd1);
        repeat (10) begin
            chk("bp_data_held", data, 32'h44332211);
            chk("bp_phy_ready_low", 32'(phy_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        dst_ready = 1'b1;
    endtask

    initial begin
        int d0;
        rst = 1'b1;
        trans_start = 1'b0;
        cfg_len = 16'h0;
        cfg_odd = 1'b0;
        mem_sel = 2'b00;
        phy_valid = 1'b0;
        phy_data = 16'h0;
        dst_ready = 1'b1;

        @(negedge clk);
        chk("rst_phy_ready", 32'(phy_ready), 32'd0);
        chk("rst_dst_valid", 32'(dst_valid), 32'd0);
        chk("rst_data", data, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Even length, natural order.
        load8({64'h0, 16'h8877, 16'h6655, 16'h4433, 16'h2211});
        run(8, 1'b0, 2'b00, 4);
        chk("t1_nwords", 32'(got_q.size()), 32'd2);
        chk("t1_w0", got_q[0], 32'h44332211);
        chk("t1_w1", got_q[1], 32'h88776655);

        // Byte-swapped memory.
        load8({64'h0, 16'h7788, 16'h5566, 16'h3344, 16'h1122});
        run(8, 1'b0, 2'b11, 4);
        chk("swap_w0", got_q[0], 32'h44332211);
        chk("swap_w1", got_q[1], 32'h88776655);

        // Odd start address, carried byte becomes the tail word.
        load8({80'h0, 16'h5544, 16'h3322, 16'h11AA});
        d0 = done_cnt;
        got_q.delete();
        start(5, 1'b1, 2'b00, 3);
        send(3);
        @(negedge clk);
        chk("odd_ready_low", 32'(phy_ready), 32'd0);
        wait_done(d0);
        chk("odd_nwords", 32'(got_q.size()), 32'd2);
        chk("odd_w0", got_q[0], 32'h44332211);
        chk("odd_w1", got_q[1], 32'h00000055);

        // Partial tail with a discarded trailing byte.
        load8({96'h0, 16'h4433, 16'h2211});
        run(3, 1'b0, 2'b01, 2);
        chk("tail_nwords", 32'(got_q.size()), 32'd1);
        chk("tail_w0", got_q[0], 32'h00332211);

        // Zero length: done only, no word.
        d0 = done_cnt;
        @(posedge clk); #1;
        cfg_len = 16'h0;
        trans_start = 1'b1;
        @(posedge clk); #1;
        trans_start = 1'b0;
        @(negedge clk);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_no_word", 32'(dst_valid), 32'd0);
        chk("zero_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("zero_done_once", 32'(done), 32'd0);

        // Reset in the middle of a transfer.
        load8({16'h10FF, 16'hEEDD, 16'hCCBB, 16'hAA99,
               16'h8877, 16'h6655, 16'h4433, 16'h2211});
        d0 = done_cnt;
        start(16, 1'b0, 2'b00, 8);
        send(3);
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_dst_valid", 32'(dst_valid), 32'd0);
        chk("abort_data", data, 32'h0);
        chk("abort_phy_ready", 32'(phy_ready), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        repeat (5) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

        // Backpressure on the uDMA side.
        d0 = done_cnt;
        got_q.delete();
        dst_ready = 1'b0;
        start(16, 1'b0, 2'b00, 8);
        fork
            send(8);
            stall();
        join
        wait_done(d0);
        chk("bp_nwords", 32'(got_q.size()), 32'd4);
        chk("bp_w0", got_q[0], 32'h44332211);
        chk("bp_w1", got_q[1], 32'h88776655);
        chk("bp_w2", got_q[2], 32'hCCBBAA99);
        chk("bp_w3", got_q[3], 32'h10FFEEDD);

        // Recovery after the abort and stall.
        load8({64'h0, 16'h8877, 16'h6655, 16'h4433, 16'h2211});
        run(7, 1'b1, 2'b00, 4);
        chk("odd7_w0", got_q[0], 32'h55443322);
        chk("odd7_w1", got_q[1], 32'h00887766);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
